// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour width, colour key and the
// per-pixel sync/blank bundle carried through the alignment pipeline.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int CLK_DIV     = 4;
  localparam int ANIM_FRAMES = 30;
  localparam int PIPE_LAT    = 1;

  localparam int                RGB_W   = 12;
  localparam logic [RGB_W-1:0]  KEY_RGB = 12'hF0F;

  typedef struct packed {
    logic video_on;
    logic hs;
    logic vs;
  } sync_t;

  // Blanked, both syncs inactive (high).
  localparam sync_t SYNC_IDLE = '{video_on: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_tick_div.sv
// Clock-enable divider: pix_tick is a registered one-clk pulse every
// CLK_DIV clocks, first asserted CLK_DIV clocks after reset release.
module vga_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int              DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      pix_tick <= (div == DIV_LAST);
      div      <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

endmodule

// File: rtl/vga_scan.sv
// VGA scan master: pixel coordinates, delayed sync/blank aligned to the
// sprite renderer, colour-keyed pixel mux and frame-rate animation toggle.
module vga_scan import vga_pkg::*; #(
  parameter int               H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int               H_FP        = vga_pkg::H_FP,
  parameter int               H_SYNC      = vga_pkg::H_SYNC,
  parameter int               H_BP        = vga_pkg::H_BP,
  parameter int               V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int               V_FP        = vga_pkg::V_FP,
  parameter int               V_SYNC      = vga_pkg::V_SYNC,
  parameter int               V_BP        = vga_pkg::V_BP,
  parameter int               CLK_DIV     = vga_pkg::CLK_DIV,
  parameter int               ANIM_FRAMES = vga_pkg::ANIM_FRAMES,
  parameter int               PIPE_LAT    = vga_pkg::PIPE_LAT,
  parameter logic [RGB_W-1:0] KEY_RGB     = vga_pkg::KEY_RGB
) (
  input  logic             clk,
  input  logic             rst,
  output logic [9:0]       col,
  output logic [9:0]       row,
  output logic             pix_tick,
  output logic             anim_toggle,
  input  logic             sprite_hit,
  input  logic [RGB_W-1:0] sprite_rgb,
  input  logic [RGB_W-1:0] bg_rgb,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             hs,
  output logic             vs
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam int            FW         = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(ANIM_FRAMES - 1);

  logic             col_last, row_last, end_of_frame;
  logic [FW-1:0]    frame_cnt;
  sync_t            raw;
  sync_t            pipe [PIPE_LAT];
  logic [RGB_W-1:0] pix_rgb, rgb_q;

  vga_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  assign col_last     = (col == H_LAST);
  assign row_last     = (row == V_LAST);
  assign end_of_frame = pix_tick && col_last && row_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      frame_cnt   <= '0;
      anim_toggle <= 1'b0;
    end else begin
      if (pix_tick) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
      if (end_of_frame) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          anim_toggle <= ~anim_toggle;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    raw          = SYNC_IDLE;
    raw.video_on = (col < H_VIS) && (row < V_VIS);
    raw.hs       = !((col >= HS_FIRST) && (col < HS_STOP));
    raw.vs       = !((row >= VS_FIRST) && (row < VS_STOP));
  end

  // Transparent sprite pixels fall through to the background colour.
  always_comb begin
    pix_rgb = '0;
    if (pipe[PIPE_LAT-1].video_on) begin
      pix_rgb = (sprite_hit && (sprite_rgb != KEY_RGB)) ? sprite_rgb : bg_rgb;
    end
  end

  // NOTE: the alignment shift register is small and its contents reach the
  // pins, so it is reset to blanked/inactive rather than left uninitialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= SYNC_IDLE;
      hs    <= 1'b1;
      vs    <= 1'b1;
      rgb_q <= '0;
    end else if (pix_tick) begin
      pipe[0] <= raw;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
      hs    <= pipe[PIPE_LAT-1].hs;
      vs    <= pipe[PIPE_LAT-1].vs;
      rgb_q <= pix_rgb;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: full-size timing on dut_a (line/pixel mux),
// a shrunken raster on dut_b (frame, vsync, animation, mid-frame reset).
module tb_vga_scan;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        sprite_hit;
  logic [11:0] sprite_rgb, bg_rgb;

  logic [9:0]  col_a, row_a, col_b, row_b;
  logic        pix_tick_a, pix_tick_b, anim_a, anim_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, hs_b, vs_b;
  logic [11:0] rgb_a, rgb_b;

  int errors = 0;
  int checks = 0;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  always #5 clk = ~clk;

  vga_scan #(.ANIM_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst_a), .col(col_a), .row(row_a), .pix_tick(pix_tick_a),
    .anim_toggle(anim_a), .sprite_hit(sprite_hit), .sprite_rgb(sprite_rgb),
    .bg_rgb(bg_rgb), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .hs(hs_a), .vs(vs_a)
  );

  // 15 x 8 raster: hsync cols 10..12, vsync rows 5..6, latency 3 ticks.
  vga_scan #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .ANIM_FRAMES(2), .PIPE_LAT(2), .KEY_RGB(12'hF0F)
  ) dut_b (
    .clk(clk), .rst(rst_b), .col(col_b), .row(row_b), .pix_tick(pix_tick_b),
    .anim_toggle(anim_b), .sprite_hit(sprite_hit), .sprite_rgb(sprite_rgb),
    .bg_rgb(bg_rgb), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hs(hs_b), .vs(vs_b)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // From a negedge: wait for pix_tick, then stop at the negedge after the
  // tick edge so the counters and output register show the update.
  task automatic adv(input bit sel, input int n);
    int budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (((sel ? pix_tick_b : pix_tick_a) !== 1'b1) && budget < 16) begin
        @(negedge clk);
        budget++;
      end
      if ((sel ? pix_tick_b : pix_tick_a) !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL adv_timeout: dut=%0d pix_tick never seen, required 1", sel);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    sprite_hit = 1'b0; sprite_rgb = 12'h000; bg_rgb = 12'h000;
    repeat (3) @(negedge clk);
    checks++; if (col_a !== 10'd0) begin errors++; $display("FAIL rst_col: got %0d want 0", col_a); end
    checks++; if (row_a !== 10'd0) begin errors++; $display("FAIL rst_row: got %0d want 0", row_a); end
    checks++; if (pix_tick_a !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", pix_tick_a); end
    checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++; $display("FAIL rst_sync: got hs/vs=%b want 11", {hs_a, vs_a}); end
    checks++; if (rgb_a !== 12'h000) begin errors++; $display("FAIL rst_rgb: got %h want 000", rgb_a); end
    checks++; if (anim_a !== 1'b0) begin errors++; $display("FAIL rst_anim: got %b want 0", anim_a); end
  endtask

  task automatic test_divider();
    bit       exp_tick;
    int       exp_col;
    rst_a = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp_tick = (n % 4 == 0);
      exp_col  = (n - 1) / 4;
      checks++; if (pix_tick_a !== exp_tick) begin errors++; $display("FAIL div_tick clk%0d: got %b want %b", n, pix_tick_a, exp_tick); end
      checks++; if (col_a !== 10'(exp_col)) begin errors++; $display("FAIL div_col clk%0d: got %0d want %0d", n, col_a, exp_col); end
    end
  endtask

  task automatic test_line();
    int b;
    int low_cnt;
    b = 0;
    while (col_a !== 10'd656 && b < 1000) begin adv(0, 1); b++; end
    checks++; if (col_a !== 10'd656) begin errors++; $display("FAIL line_reach656: got %0d want 656", col_a); end
    adv(0, 1);
    checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL hs_before: got %b want 1", hs_a); end
    adv(0, 1);
    checks++; if (hs_a !== 1'b0) begin errors++; $display("FAIL hs_first_low: got %b want 0", hs_a); end
    low_cnt = 1;
    b = 0;
    while (hs_a === 1'b0 && b < 200) begin
      adv(0, 1);
      if (hs_a === 1'b0) low_cnt++;
      b++;
    end
    checks++; if (low_cnt != 96) begin errors++; $display("FAIL hs_width: got %0d want 96", low_cnt); end
    b = 0;
    while (col_a !== 10'd799 && b < 200) begin adv(0, 1); b++; end
    checks++; if (row_a !== 10'd0) begin errors++; $display("FAIL line_row_end: got %0d want 0", row_a); end
    adv(0, 1);
    checks++; if ({col_a, row_a} !== {10'd0, 10'd1}) begin errors++; $display("FAIL line_wrap: got col=%0d row=%0d want col=0 row=1", col_a, row_a); end
  endtask

  task automatic test_pixel_mux();
    int b;
    sprite_hit = 1'b1; sprite_rgb = 12'h5A3; bg_rgb = 12'h111;
    adv(0, 1);
    checks++; if (rgb_a !== 12'h000) begin errors++; $display("FAIL mux_blank_prev: got %h want 000", rgb_a); end
    adv(0, 1);
    checks++; if (rgb_a !== 12'h5A3) begin errors++; $display("FAIL mux_sprite: got %h want 5a3", rgb_a); end
    sprite_rgb = 12'hF0F;
    adv(0, 1);
    checks++; if (rgb_a !== 12'h111) begin errors++; $display("FAIL mux_key: got %h want 111", rgb_a); end
    sprite_hit = 1'b0; sprite_rgb = 12'h5A3;
    adv(0, 1);
    checks++; if (rgb_a !== 12'h111) begin errors++; $display("FAIL mux_nohit: got %h want 111", rgb_a); end
    sprite_hit = 1'b1;
    b = 0;
    while (col_a !== 10'd640 && b < 800) begin adv(0, 1); b++; end
    adv(0, 1);
    checks++; if (rgb_a !== 12'h5A3) begin errors++; $display("FAIL mux_col639: got %h want 5a3", rgb_a); end
    adv(0, 1);
    checks++; if (rgb_a !== 12'h000) begin errors++; $display("FAIL mux_col640: got %h want 000", rgb_a); end
  endtask

  task automatic test_frame();
    int vs_cnt;
    int vs_first;
    vs_cnt = 0;
    vs_first = -1;
    rst_b = 1'b0;
    for (int t = 1; t <= 120; t++) begin
      adv(1, 1);
      if (vs_b === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
      end
      if (t == 119) begin
        checks++; if ({col_b, row_b} !== {10'd14, 10'd7}) begin errors++; $display("FAIL frame_last: got col=%0d row=%0d want 14/7", col_b, row_b); end
      end
      if (t == 120) begin
        checks++; if ({col_b, row_b} !== {10'd0, 10'd0}) begin errors++; $display("FAIL frame_wrap: got col=%0d row=%0d want 0/0", col_b, row_b); end
        checks++; if (anim_b !== 1'b0) begin errors++; $display("FAIL anim_frame1: got %b want 0", anim_b); end
      end
    end
    checks++; if (vs_cnt != 30) begin errors++; $display("FAIL vs_width: got %0d want 30", vs_cnt); end
    checks++; if (vs_first != 78) begin errors++; $display("FAIL vs_first: got %0d want 78", vs_first); end
  endtask

  task automatic test_anim();
    bit exp;
    for (int t = 121; t <= 480; t++) begin
      adv(1, 1);
      if (t == 239 || t == 240 || t == 479 || t == 480) begin
        exp = (t == 240 || t == 479);
        checks++; if (anim_b !== exp) begin errors++; $display("FAIL anim_t%0d: got %b want %b", t, anim_b, exp); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    sprite_hit = 1'b1; sprite_rgb = 12'h5A3; bg_rgb = 12'h111;
    adv(1, 290);
    checks++; if ({col_b, row_b} !== {10'd5, 10'd3}) begin errors++; $display("FAIL mid_pos: got col=%0d row=%0d want 5/3", col_b, row_b); end
    checks++; if (anim_b !== 1'b1) begin errors++; $display("FAIL mid_anim: got %b want 1", anim_b); end
    checks++; if (rgb_b !== 12'h5A3) begin errors++; $display("FAIL mid_rgb: got %h want 5a3", rgb_b); end
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    checks++; if ({col_b, row_b} !== 20'd0) begin errors++; $display("FAIL mid_rst_pos: got col=%0d row=%0d want 0/0", col_b, row_b); end
    checks++; if ({hs_b, vs_b} !== 2'b11) begin errors++; $display("FAIL mid_rst_sync: got %b want 11", {hs_b, vs_b}); end
    checks++; if (rgb_b !== 12'h000) begin errors++; $display("FAIL mid_rst_rgb: got %h want 000", rgb_b); end
    checks++; if (anim_b !== 1'b0) begin errors++; $display("FAIL mid_rst_anim: got %b want 0", anim_b); end
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (pix_tick_b !== (n == 4)) begin errors++; $display("FAIL mid_restart_tick clk%0d: got %b want %b", n, pix_tick_b, (n == 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_line();
    test_pixel_mux();
    test_frame();
    test_anim();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
